// File: rtl/rtp_result_pkg.sv
// rtl/rtp_result_pkg.sv - shared constants, state enum and hit record for the hit result collector
package rtp_result_pkg;

   localparam logic [31:0] FP_POS_INF = 32'h7F800000;
   localparam logic [31:0] TRI_NONE   = 32'hFFFFFFFF;

   typedef enum logic [1:0] {INIT, RUN, DONE} collector_state_e;

   typedef struct packed {
      logic [31:0] hitT;
      logic [31:0] tri_id;
   } hit_rec_t;

endpackage

// File: rtl/hit_result_collector_if.sv
// rtl/hit_result_collector_if.sv - candidate input stream and retired-ray output bundle
interface hit_result_collector_if #(
   parameter int RAY_ID_W = 10,
   parameter int TRI_ID_W = 32
);
   logic                io_in_valid;
   logic                io_in_ready;
   logic [RAY_ID_W-1:0] io_in_ray_id;
   logic [31:0]         io_in_hitT;
   logic [TRI_ID_W-1:0] io_in_tri_id;
   logic                io_in_last;
   logic                io_out_valid;
   logic [31:0]         io_hitT;
   logic [31:0]         io_ray_id_triangle;
   logic [RAY_ID_W-1:0] io_out_ray_id;

   modport master (
      output io_in_valid, io_in_ray_id, io_in_hitT, io_in_tri_id, io_in_last,
      input  io_in_ready, io_out_valid, io_hitT, io_ray_id_triangle, io_out_ray_id
   );

   modport slave (
      input  io_in_valid, io_in_ray_id, io_in_hitT, io_in_tri_id, io_in_last,
      output io_in_ready, io_out_valid, io_hitT, io_ray_id_triangle, io_out_ray_id
   );
endinterface

// File: rtl/result_ram_1r1w.sv
// rtl/result_ram_1r1w.sv - synchronous 1-read/1-write RAM of hit records
// Read-first: a read of the address being written returns the old contents.
module result_ram_1r1w
   import rtp_result_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  hit_rec_t      wdata_i,
   input  logic [AW-1:0] raddr_i,
   output hit_rec_t      rdata_o
);
   hit_rec_t mem_q [DEPTH];
   hit_rec_t rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/hit_result_collector.sv
// rtl/hit_result_collector.sv - keeps the closest hit per ray, retires rays, serves readback
// Optional macro HIT_CYCLE_COUNTER_EN adds io_counter_fdiv (RUN-to-finish cycle count).
module hit_result_collector
   import rtp_result_pkg::*;
#(
   parameter int NUM_RAYS = 1024,
   parameter int RAY_ID_W = 10,
   parameter int TRI_ID_W = 32
) (
   input  logic                clock,
   input  logic                reset,
   hit_result_collector_if.slave bus,
   output logic                io_rtp_finish,
   input  logic [RAY_ID_W-1:0] io_rd_addr,
   output logic [31:0]         io_rd_data_hitT,
   output logic [31:0]         io_rd_data_tri
`ifdef HIT_CYCLE_COUNTER_EN
   ,
   output logic [63:0]         io_counter_fdiv
`endif
);
   localparam logic [RAY_ID_W-1:0] LAST_ADDR  = RAY_ID_W'(NUM_RAYS - 1);
   localparam logic [RAY_ID_W:0]   NUM_RETIRE = (RAY_ID_W+1)'(NUM_RAYS);
   localparam logic [RAY_ID_W+1:0] NUM_COMMIT = (RAY_ID_W+2)'(NUM_RAYS);

   collector_state_e    state_q, state_d;
   logic [RAY_ID_W-1:0] init_addr_q, init_addr_d;
   logic [RAY_ID_W:0]   retired_q, retired_d;

   logic                s1_valid_q, s1_last_q;
   logic [RAY_ID_W-1:0] s1_ray_q;
   logic [31:0]         s1_hitT_q, s1_tri_q;
   logic                fwd_q;
   hit_rec_t            fwd_rec_q;
   logic                out_valid_q;
   hit_rec_t            out_rec_q;
   logic [RAY_ID_W-1:0] out_ray_q;
   logic                rd_active_q;

   logic [TRI_ID_W-1:0] in_tri;
   logic [RAY_ID_W+1:0] committed;
   logic                accept;
   hit_rec_t            ram_rdata, ram_wdata, stored, merged;
   logic                ram_we;
   logic [RAY_ID_W-1:0] ram_waddr, ram_raddr;

   assign in_tri = bus.io_in_tri_id;

   // Retired rays plus lasts still in the pipe; once this reaches NUM_RAYS nothing more may enter.
   assign committed = {1'b0, retired_q}
                    + (RAY_ID_W+2)'(s1_valid_q & s1_last_q)
                    + (RAY_ID_W+2)'(out_valid_q);
   assign bus.io_in_ready = (state_q == RUN) && (committed < NUM_COMMIT);
   assign accept          = bus.io_in_valid && bus.io_in_ready;

   // The RAM read issued alongside S1's write is stale for the same ray, so use the forwarded merge.
   assign stored = fwd_q ? fwd_rec_q : ram_rdata;
   assign merged = (s1_hitT_q < stored.hitT) ? {s1_hitT_q, s1_tri_q} : stored;

   always_comb begin
      state_d     = state_q;
      init_addr_d = init_addr_q;
      retired_d   = retired_q + {{RAY_ID_W{1'b0}}, out_valid_q};
      ram_we      = 1'b0;
      ram_waddr   = s1_ray_q;
      ram_wdata   = merged;
      ram_raddr   = bus.io_in_ray_id;
      case (state_q)
         INIT: begin
            ram_we      = 1'b1;
            ram_waddr   = init_addr_q;
            ram_wdata   = {FP_POS_INF, TRI_NONE};
            init_addr_d = init_addr_q + 1'b1;
            if (init_addr_q == LAST_ADDR) state_d = RUN;
         end
         RUN: begin
            ram_we = s1_valid_q;
            if (retired_d == NUM_RETIRE) state_d = DONE;
         end
         DONE: begin
            ram_raddr = io_rd_addr;
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= INIT;
         init_addr_q <= '0;
         retired_q   <= '0;
         s1_valid_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         s1_ray_q    <= '0;
         s1_hitT_q   <= '0;
         s1_tri_q    <= '0;
         fwd_q       <= 1'b0;
         fwd_rec_q   <= '0;
         out_valid_q <= 1'b0;
         out_rec_q   <= '0;
         out_ray_q   <= '0;
         rd_active_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_addr_q <= init_addr_d;
         retired_q   <= retired_d;
         s1_valid_q  <= accept;
         if (accept) begin
            s1_last_q <= bus.io_in_last;
            s1_ray_q  <= bus.io_in_ray_id;
            s1_hitT_q <= bus.io_in_hitT;
            s1_tri_q  <= 32'(in_tri);
         end
         fwd_q       <= s1_valid_q && (s1_ray_q == bus.io_in_ray_id);
         fwd_rec_q   <= merged;
         out_valid_q <= s1_valid_q && s1_last_q;
         if (s1_valid_q && s1_last_q) begin
            out_rec_q <= merged;
            out_ray_q <= s1_ray_q;
         end
         rd_active_q <= (state_q == DONE);
      end
   end

   result_ram_1r1w #(
      .DEPTH (NUM_RAYS),
      .AW    (RAY_ID_W)
   ) u_ram (
      .clk     (clock),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (ram_wdata),
      .raddr_i (ram_raddr),
      .rdata_o (ram_rdata)
   );

   assign bus.io_out_valid       = out_valid_q;
   assign bus.io_hitT            = out_rec_q.hitT;
   assign bus.io_ray_id_triangle = out_rec_q.tri_id;
   assign bus.io_out_ray_id      = out_ray_q;
   assign io_rtp_finish          = (state_q == DONE);
   assign io_rd_data_hitT        = rd_active_q ? ram_rdata.hitT   : 32'd0;
   assign io_rd_data_tri         = rd_active_q ? ram_rdata.tri_id : 32'd0;

`ifdef HIT_CYCLE_COUNTER_EN
   logic [63:0] cycle_cnt_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         cycle_cnt_q <= '0;
      end else if (state_q == RUN) begin
         cycle_cnt_q <= cycle_cnt_q + 64'd1;
      end
   end

   assign io_counter_fdiv = cycle_cnt_q;
`endif
endmodule

// File: tb/tb_hit_result_collector.sv
// tb/tb_hit_result_collector.sv - randomized self-checking bench for hit_result_collector
// Optional macro HIT_CYCLE_COUNTER_EN enables the cycle counter checks.
module tb_hit_result_collector;
   import rtp_result_pkg::*;

   localparam int NR = 16;
   localparam int RW = 4;
   localparam int TW = 16;

   typedef struct {
      int          ray;
      logic [31:0] hitT;
      logic [31:0] tri_id;
      int          cyc;
   } ev_t;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          finish;
   logic [RW-1:0] rd_addr;
   logic [31:0]   rd_hitT, rd_tri;
`ifdef HIT_CYCLE_COUNTER_EN
   logic [63:0]   counter;
`endif

   int tests = 0;
   int fails = 0;

   ev_t         exp_q[$];
   ev_t         obs_q[$];
   logic [31:0] best_hitT [NR];
   logic [31:0] best_tri  [NR];
   int          ncyc = 0;
   int          fin_cyc = -1;
   int          run_cyc = -1;
   int          last_out_cyc = -1;

   always #5 clock = ~clock;

   hit_result_collector_if #(.RAY_ID_W(RW), .TRI_ID_W(TW)) bus ();

   hit_result_collector #(
      .NUM_RAYS (NR),
      .RAY_ID_W (RW),
      .TRI_ID_W (TW)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .bus             (bus),
      .io_rtp_finish   (finish),
      .io_rd_addr      (rd_addr),
      .io_rd_data_hitT (rd_hitT),
      .io_rd_data_tri  (rd_tri)
`ifdef HIT_CYCLE_COUNTER_EN
      ,
      .io_counter_fdiv (counter)
`endif
   );

   // Reference: per-ray minimum (strictly smaller wins), retire due two cycles after the last is accepted.
   always @(negedge clock) begin : recorder
      int r;
      ncyc++;
      if (reset) begin
         exp_q.delete();
         obs_q.delete();
         for (int i = 0; i < NR; i++) begin
            best_hitT[i] = FP_POS_INF;
            best_tri[i]  = TRI_NONE;
         end
         fin_cyc = -1;
         run_cyc = -1;
         last_out_cyc = -1;
      end else begin
         if (run_cyc < 0 && bus.io_in_ready) run_cyc = ncyc;
         if (fin_cyc < 0 && finish) fin_cyc = ncyc;
         if (bus.io_in_valid && bus.io_in_ready) begin
            r = int'(bus.io_in_ray_id);
            if (bus.io_in_hitT < best_hitT[r]) begin
               best_hitT[r] = bus.io_in_hitT;
               best_tri[r]  = 32'(bus.io_in_tri_id);
            end
            if (bus.io_in_last) exp_q.push_back('{r, best_hitT[r], best_tri[r], ncyc + 2});
         end
         if (bus.io_out_valid) begin
            obs_q.push_back('{int'(bus.io_out_ray_id), bus.io_hitT, bus.io_ray_id_triangle, ncyc});
            last_out_cyc = ncyc;
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic send(input int ray, input logic [31:0] h, input logic [31:0] t, input bit last);
      int n = 0;
      bus.io_in_valid  = 1'b1;
      bus.io_in_ray_id = RW'(ray);
      bus.io_in_hitT   = h;
      bus.io_in_tri_id = TW'(t);
      bus.io_in_last   = last;
      while (!bus.io_in_ready && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) begin
         tests++; fails++;
         $display("FAIL send_timeout ray=%0d ready=%b required=1", ray, bus.io_in_ready);
      end
      tick();
      bus.io_in_valid = 1'b0;
   endtask

   task automatic wait_out(input int need, input string name);
      int n = 0;
      while (obs_q.size() < need && n < 50) begin
         tick();
         n++;
      end
      if (obs_q.size() < need) begin
         tests++; fails++;
         $display("FAIL %s_timeout outputs=%0d required=%0d", name, obs_q.size(), need);
      end
   endtask

   task automatic test_reset();
      int n = 0;
      reset = 1'b1;
      tick(3);
      tests++;
      if (bus.io_in_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got=%b want=0", bus.io_in_ready); end
      tests++;
      if (bus.io_out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b want=0", bus.io_out_valid); end
      tests++;
      if (finish !== 1'b0) begin fails++; $display("FAIL reset_finish got=%b want=0", finish); end
      tests++;
      if ({rd_hitT, rd_tri} !== 64'd0) begin fails++; $display("FAIL reset_rd_data got=%h want=0", {rd_hitT, rd_tri}); end
      reset = 1'b0;
      while (!bus.io_in_ready && n < 100) begin
         tick();
         n++;
      end
      tests++;
      if (n !== NR) begin fails++; $display("FAIL init_ready_low cycles=%0d want=%0d", n, NR); end
   endtask

   task automatic test_forwarding();
      ev_t o, e;
      send(5, 32'h40400000, 7, 1'b0);
      send(5, 32'h3F800000, 9, 1'b1);
      wait_out(1, "fwd");
      if (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         tests++;
         if ({o.ray, o.hitT, o.tri_id} !== {32'd5, 32'h3F800000, 32'd9}) begin
            fails++;
            $display("FAIL fwd_result got ray=%0d hitT=%h tri=%h want ray=5 hitT=3f800000 tri=00000009", o.ray, o.hitT, o.tri_id);
         end
         tests++;
         if (o.cyc !== e.cyc) begin fails++; $display("FAIL fwd_latency got cycle=%0d want=%0d", o.cyc, e.cyc); end
      end
   endtask

   task automatic test_tie();
      ev_t o, e;
      send(3, 32'h40000000, 1, 1'b0);
      send(3, 32'h40000000, 2, 1'b1);
      wait_out(1, "tie");
      if (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         tests++;
         if ({o.ray, o.hitT, o.tri_id} !== {32'd3, 32'h40000000, 32'd1}) begin
            fails++;
            $display("FAIL tie_result got ray=%0d hitT=%h tri=%h want ray=3 hitT=40000000 tri=00000001", o.ray, o.hitT, o.tri_id);
         end
         tests++;
         if (o.cyc !== e.cyc) begin fails++; $display("FAIL tie_latency got cycle=%0d want=%0d", o.cyc, e.cyc); end
      end
   endtask

   task automatic test_miss();
      ev_t o, e;
      send(8, FP_POS_INF, 42, 1'b1);
      wait_out(1, "miss");
      if (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         tests++;
         if ({o.ray, o.hitT, o.tri_id} !== {32'd8, 32'h7F800000, 32'hFFFFFFFF}) begin
            fails++;
            $display("FAIL miss_result got ray=%0d hitT=%h tri=%h want ray=8 hitT=7f800000 tri=ffffffff", o.ray, o.hitT, o.tri_id);
         end
         tests++;
         if (o.cyc !== e.cyc) begin fails++; $display("FAIL miss_latency got cycle=%0d want=%0d", o.cyc, e.cyc); end
      end
   endtask

   task automatic test_random();
      int pend[$];
      int quota[NR];
      int prev = -1;
      int idx, r;
      bit last;
      logic [31:0] h;
      ev_t o, e;
      for (int i = 0; i < NR; i++) begin
         if (i != 3 && i != 5 && i != 8) begin
            pend.push_back(i);
            quota[i] = int'($urandom_range(1, 4));
         end
      end
      while (pend.size() > 0) begin
         idx = int'($urandom_range(0, pend.size() - 1));
         if (prev >= 0 && $urandom_range(0, 1) == 1) begin
            for (int k = 0; k < pend.size(); k++) if (pend[k] == prev) idx = k;
         end
         r = pend[idx];
         quota[r]--;
         last = (quota[r] == 0);
         h = ($urandom_range(0, 5) == 0) ? FP_POS_INF : 32'h3F000000 + ($urandom_range(0, 15) << 19);
         send(r, h, $urandom_range(0, 65535), last);
         if (last) begin
            pend.delete(idx);
            prev = -1;
         end else begin
            prev = r;
         end
         if ($urandom_range(0, 3) == 0) tick(int'($urandom_range(1, 2)));
      end
      tick(6);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         tests++;
         if (obs_q.size() == 0) begin
            fails++;
            $display("FAIL rand_missing ray=%0d outputs=0 required=1", e.ray);
         end else begin
            o = obs_q.pop_front();
            if ({o.ray, o.hitT, o.tri_id, o.cyc} !== {e.ray, e.hitT, e.tri_id, e.cyc}) begin
               fails++;
               $display("FAIL rand_result got ray=%0d hitT=%h tri=%h cyc=%0d want ray=%0d hitT=%h tri=%h cyc=%0d",
                        o.ray, o.hitT, o.tri_id, o.cyc, e.ray, e.hitT, e.tri_id, e.cyc);
            end
         end
      end
      tests++;
      if (obs_q.size() !== 0) begin fails++; $display("FAIL rand_extra outputs=%0d want=0", obs_q.size()); end
   endtask

   task automatic test_finish();
      tests++;
      if (fin_cyc !== last_out_cyc + 1) begin
         fails++;
         $display("FAIL finish_timing got cycle=%0d want=%0d", fin_cyc, last_out_cyc + 1);
      end
      tests++;
      if ({finish, bus.io_in_ready} !== 2'b10) begin
         fails++;
         $display("FAIL done_levels got finish=%b ready=%b want finish=1 ready=0", finish, bus.io_in_ready);
      end
      bus.io_in_valid  = 1'b1;
      bus.io_in_ray_id = '0;
      bus.io_in_hitT   = 32'd0;
      bus.io_in_tri_id = TW'(5);
      bus.io_in_last   = 1'b1;
      tick(5);
      bus.io_in_valid = 1'b0;
      tests++;
      if (obs_q.size() !== 0 || bus.io_in_ready !== 1'b0) begin
         fails++;
         $display("FAIL done_ignores_input outputs=%0d ready=%b want outputs=0 ready=0", obs_q.size(), bus.io_in_ready);
      end
      for (int a = 0; a < NR; a++) begin
         rd_addr = RW'(a);
         tick();
         tests++;
         if ({rd_hitT, rd_tri} !== {best_hitT[a], best_tri[a]}) begin
            fails++;
            $display("FAIL readback addr=%0d got hitT=%h tri=%h want hitT=%h tri=%h", a, rd_hitT, rd_tri, best_hitT[a], best_tri[a]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      while (!bus.io_in_ready && n < 100) begin tick(); n++; end
      for (int r = 0; r < 5; r++) send(r, 32'h3E000000 + r, r + 100, 1'b1);
      reset = 1'b1;
      tick();
      tests++;
      if ({bus.io_out_valid, bus.io_in_ready, finish} !== 3'b000) begin
         fails++;
         $display("FAIL midreset_outputs got valid=%b ready=%b finish=%b want 0 0 0", bus.io_out_valid, bus.io_in_ready, finish);
      end
`ifdef HIT_CYCLE_COUNTER_EN
      tests++;
      if (counter !== 64'd0) begin fails++; $display("FAIL midreset_counter got=%0d want=0", counter); end
`endif
      tick();
      reset = 1'b0;
      n = 0;
      while (!bus.io_in_ready && n < 100) begin tick(); n++; end
      tests++;
      if (n !== NR) begin fails++; $display("FAIL reinit_ready_low cycles=%0d want=%0d", n, NR); end
      tests++;
      if (finish !== 1'b0) begin fails++; $display("FAIL reinit_finish got=%b want=0", finish); end
      for (int r = 0; r < NR; r++) send(r, FP_POS_INF, $urandom_range(0, 65535), 1'b1);
      tick(6);
      tests++;
      if (obs_q.size() !== NR || exp_q.size() !== NR) begin
         fails++;
         $display("FAIL rerun_retired got=%0d want=%0d", obs_q.size(), exp_q.size());
      end
      tests++;
      if (fin_cyc !== last_out_cyc + 1) begin
         fails++;
         $display("FAIL rerun_finish_timing got cycle=%0d want=%0d", fin_cyc, last_out_cyc + 1);
      end
`ifdef HIT_CYCLE_COUNTER_EN
      tests++;
      if (counter !== 64'(fin_cyc - run_cyc)) begin
         fails++;
         $display("FAIL counter_value got=%0d want=%0d", counter, fin_cyc - run_cyc);
      end
      tick(5);
      tests++;
      if (counter !== 64'(fin_cyc - run_cyc)) begin
         fails++;
         $display("FAIL counter_frozen got=%0d want=%0d", counter, fin_cyc - run_cyc);
      end
`endif
      for (int a = 0; a < NR; a++) begin
         rd_addr = RW'(a);
         tick();
         tests++;
         if ({rd_hitT, rd_tri} !== {32'h7F800000, 32'hFFFFFFFF}) begin
            fails++;
            $display("FAIL reinit_readback addr=%0d got hitT=%h tri=%h want hitT=7f800000 tri=ffffffff", a, rd_hitT, rd_tri);
         end
      end
   endtask

   initial begin
      bus.io_in_valid  = 1'b0;
      bus.io_in_ray_id = '0;
      bus.io_in_hitT   = '0;
      bus.io_in_tri_id = '0;
      bus.io_in_last   = 1'b0;
      rd_addr          = '0;
      test_reset();
      test_forwarding();
      test_tie();
      test_miss();
      test_random();
      test_finish();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time=%0t limit=200000", $time);
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/hit_result_collector.md
Name: hit_result_collector

Overview:
- Sits directly downstream of the triangle-intersection stage of the ray-tracing pipeline.
- Consumes the stream of per-triangle hit candidates (ray id, hitT, triangle id) and keeps the closest hit per ray in a result RAM.
- Retires rays when their last candidate arrives and raises the global finish flag once all rays are retired.
- After finish, provides a readback port for the final hitT/triangle per ray.

Parameters:
- NUM_RAYS, 1024, number of rays in the batch; the result RAM depth.
- RAY_ID_W, 10, ray id width; must satisfy 2^RAY_ID_W >= NUM_RAYS.
- TRI_ID_W, 32, triangle id width.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high.
- io_in_valid  in  1  candidate valid.
- io_in_ready  out  1  collector accepts the candidate this cycle.
- io_in_ray_id  in  RAY_ID_W  ray index.
- io_in_hitT  in  32  IEEE-754 single, non-negative; +inf (0x7F800000) means miss.
- io_in_tri_id  in  TRI_ID_W  triangle index of the candidate.
- io_in_last  in  1  final candidate for this ray.
- io_out_valid  out  1  one-cycle pulse per retired ray.
- io_hitT  out  32  closest hitT of the retired ray.
- io_ray_id_triangle  out  32  triangle id of the closest hit (0xFFFFFFFF if miss), zero-extended.
- io_out_ray_id  out  RAY_ID_W  retired ray id.
- io_rtp_finish  out  1  level; high once NUM_RAYS rays are retired.
- io_rd_addr  in  RAY_ID_W  readback address, honoured only when finish is high.
- io_rd_data_hitT  out  32  readback hitT, 1-cycle latency.
- io_rd_data_tri  out  32  readback triangle, 1-cycle latency.

Behaviour:
- FSM states: INIT, RUN, DONE.
- Reset:
  - enters INIT with init address 0.
  - All outputs 0, except io_in_ready=0 and io_rtp_finish=0.
  - Reset mid-operation discards the pipeline and all counts, then restarts INIT.
- INIT:
  - Writes {0x7F800000, 0xFFFFFFFF} to one RAM address per cycle, for NUM_RAYS cycles.
  - Then goes to RUN. io_in_ready=0 throughout.
- RUN:
  - io_in_ready=1; a transfer occurs on valid&&ready.
  - Two-stage pipeline: S0 issues the RAM read of ray_id and registers the candidate. S1 compares and writes.
  - Compare: hitT is compared as unsigned 32-bit (valid for non-negative floats). The candidate replaces the stored hit only if strictly smaller; ties keep the stored (earlier) hit.
  - Hazard: if the S1 write targets the same ray_id as S0's read, S0 uses the forwarded S1 result instead of the RAM data. Back-to-back same-ray candidates must therefore be correct at full rate.
  - Retire: when S1 holds last=1, io_out_valid pulses in the cycle after S1 and carries the merged result. The retired counter then increments.
  - Latency: input accept to io_out_valid = 2 cycles.
  - A ray retired twice is counted twice; avoiding this is the upstream stage's responsibility.
- DONE:
  - Entered when the retired counter reaches NUM_RAYS.
  - io_rtp_finish=1 and io_in_ready=0; inputs are ignored.
  - The readback port is active; io_rd_data is held at 0 outside DONE.
  - Leaves DONE only on reset.
- The retired counter is RAY_ID_W+1 bits wide, so NUM_RAYS = 2^RAY_ID_W does not wrap.
- A transfer arriving in the final retiring cycle cannot occur: ready drops the cycle the count reaches NUM_RAYS−1 with a last in S1 or S0. Specifically, ready is deasserted while the number of retired rays plus in-flight lasts equals NUM_RAYS.

Optional Feature:
- Macro: HIT_CYCLE_COUNTER_EN.
- Defined:
  - adds output io_counter_fdiv [63:0].
  - Counts clock cycles from entering RUN until io_rtp_finish rises, then freezes.
  - Reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package rtp_result_pkg holds:
  - constants FP_POS_INF=32'h7F800000 and TRI_NONE=32'hFFFFFFFF.
  - collector state enum {INIT, RUN, DONE}.
  - packed struct hit_rec_t {hitT[31:0], tri[31:0]}.
- One natural sub-module: result_ram_1r1w, a synchronous single-read/single-write RAM of hit_rec_t with read-first semantics. The forwarding logic stays in the collector.

Test Plan:
- Reset then wait: io_in_ready low for exactly NUM_RAYS cycles, then high; readback of any address after forced finish = {0x7F800000, 0xFFFFFFFF}.
- Ray 5 receives hitT 0x40400000 (tri 7), then 0x3F800000 (tri 9, last) back-to-back → io_out_valid 2 cycles after the last; hitT=0x3F800000, tri=9 (exercises forwarding).
- Ray 3 receives 0x40000000 (tri 1), then an equal 0x40000000 (tri 2, last) → retired tri=1 (tie keeps the earlier hit).
- Ray 8 receives a single miss 0x7F800000 with last=1 → hitT=0x7F800000, tri=0xFFFFFFFF.
- NUM_RAYS=4, retire rays 0..3 with random gaps → io_rtp_finish rises the cycle after the 4th io_out_valid; io_in_ready stays 0 afterwards; readback io_rd_addr=2 returns the stored values 1 cycle later.
- HIT_CYCLE_COUNTER_EN with NUM_RAYS=4, finish 20 cycles after RUN → io_counter_fdiv=20 and stays constant thereafter; assert reset mid-RUN → counter=0 and INIT restarts.
